// File: rtl/ram_responder_pkg.sv
// Shared constants for the RAM responder slice.
// FSM encodings, byte/word geometry and default data width.
package ram_responder_pkg;

  localparam int DEFAULT_WIDTH    = 32;
  localparam int WORD_BYTES       = 4;
  localparam int BYTE_OFFSET_BITS = 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

endpackage

// File: rtl/ram_array.sv
// Word storage: synchronous write, asynchronous read.
// Ports: clk, we/widx/wdata write side, ridx/rdata read side.
module ram_array
  import ram_responder_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] widx,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] ridx,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder with wait states and ready handshake.
// Ports: clk, reset, addIn, dataRAM (bidir), rd, wr, ready, errOut.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int ADDR_BITS   = 6,
  parameter int WAIT_STATES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] addIn,
  inout  wire  [WIDTH-1:0] dataRAM,
  input  logic             rd,
  input  logic             wr,
  output logic             ready,
  output logic             errOut
);

  localparam int HI = ADDR_BITS + BYTE_OFFSET_BITS;
  localparam int CW =
    (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam int CINIT =
    (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic [ADDR_BITS-1:0] idx_q;
  logic                 rd_q;
  logic                 wr_q;
  logic                 oor_q;
  logic                 fault_q;

  logic                 both;
  logic                 mis;
  logic                 oor;
  logic                 accept;
  logic                 to_resp;
  logic                 we;
  logic                 bus_en;
  logic [ADDR_BITS-1:0] in_idx;
  logic [ADDR_BITS-1:0] widx;
  logic [WIDTH-1:0]     rdata;

  assign both   = rd && wr;
  assign mis    = |addIn[BYTE_OFFSET_BITS-1:0];
  assign oor    = |(addIn >> HI);
  assign in_idx = addIn[HI-1:BYTE_OFFSET_BITS];
  assign accept = (state == IDLE) && (rd || wr);

  // With zero wait states the commit edge is the
  // accept edge, so the write uses live inputs.
  assign to_resp =
    (accept && (WAIT_STATES == 0)) ||
    ((state == WAIT) && (cnt == '0));

  assign widx = (state == IDLE) ? in_idx : idx_q;

  always_comb begin
    we = 1'b0;
    if (to_resp && !reset) begin
      if (state == IDLE) we = wr && !rd && !oor;
      else               we = wr_q && !oor_q;
    end
  end

  ram_array #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .widx  (widx),
    .wdata (dataRAM),
    .ridx  (idx_q),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            idx_q   <= in_idx;
            rd_q    <= rd && !wr;
            wr_q    <= wr && !rd;
            oor_q   <= oor;
            fault_q <= both || mis || oor;
            if (WAIT_STATES > 0) begin
              state <= WAIT;
              cnt   <= CW'(CINIT);
            end else begin
              state <= RESP;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - CW'(1);
        end
        RESP: begin
          if (!rd && !wr) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready  = (state == RESP);
  assign errOut = ready && fault_q;

  // Never drive while the requester may be driving.
  assign bus_en = ready && rd_q && rd && !wr;

  assign dataRAM =
    bus_en ? (oor_q ? '0 : rdata) : 'z;

endmodule
